// File: rtl/fifo_1w_2r.sv
// One-write / pair-read FIFO with occupancy, full, pair-available and sticky overflow flags.
// Optional single-entry flush pop enabled by defining FIFO_1W2R_FLUSH_EN.
module fifo_1w_2r #(
  parameter int DATA_WIDTH    = 65,
  parameter int ADDRESS_WIDTH = 3,
  parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Clear_in,
  input  logic                     stall,
  input  logic [DATA_WIDTH-1:0]    Data_in,
  input  logic                     WriteEn_in,
  output logic                     Full_out,
  input  logic                     ReadEn_in,
  input  logic                     Flush_in,
  output logic [DATA_WIDTH-1:0]    Data_out_1,
  output logic [DATA_WIDTH-1:0]    Data_out_2,
  output logic                     Data_valid,
  output logic                     Data_valid_2,
  output logic                     Empty_out,
  output logic [ADDRESS_WIDTH:0]   Count_out,
  output logic                     Overflow_out
);

  localparam int CW = ADDRESS_WIDTH + 1;

  logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wp;
  logic [ADDRESS_WIDTH-1:0] rp;
  logic [ADDRESS_WIDTH-1:0] rp_nxt;
  logic [CW-1:0]            count;
  logic [CW-1:0]            count_nxt;
  logic                     wr;
  logic                     rd2;
  logic                     rdf;

  // Flags decode the count register only, so no input reaches them combinationally.
  assign Full_out  = (count == CW'(FIFO_DEPTH));
  assign Empty_out = (count < CW'(2));
  assign Count_out = count;

  assign wr     = WriteEn_in & ~Full_out & ~stall;
  assign rd2    = ReadEn_in & ~Empty_out & ~stall;
  assign rp_nxt = rp + ADDRESS_WIDTH'(1);

`ifdef FIFO_1W2R_FLUSH_EN
  assign rdf = Flush_in & ~ReadEn_in & (count == CW'(1)) & ~stall;
`else
  logic unused_flush;
  assign unused_flush = Flush_in;
  assign rdf          = 1'b0;
`endif

  always_comb begin
    count_nxt = count;
    if (wr)  count_nxt = count_nxt + CW'(1);
    if (rd2) count_nxt = count_nxt - CW'(2);
    if (rdf) count_nxt = count_nxt - CW'(1);
  end

  // Storage has no reset; clear/reset only moves the pointers.
  always_ff @(posedge Clk) begin
    if (wr) mem[wp] <= Data_in;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      Data_out_1   <= '0;
      Data_out_2   <= '0;
      Data_valid   <= 1'b0;
      Data_valid_2 <= 1'b0;
      Overflow_out <= 1'b0;
    end else if (Clear_in) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      Data_out_1   <= '0;
      Data_out_2   <= '0;
      Data_valid   <= 1'b0;
      Data_valid_2 <= 1'b0;
      Overflow_out <= 1'b0;
    end else begin
      count        <= count_nxt;
      Data_valid   <= rd2 | rdf;
      Data_valid_2 <= rd2;
      if (wr) wp <= wp + ADDRESS_WIDTH'(1);
      if (rd2) begin
        Data_out_1 <= mem[rp];
        Data_out_2 <= mem[rp_nxt];
        rp         <= rp + ADDRESS_WIDTH'(2);
      end else if (rdf) begin
        Data_out_1 <= mem[rp];
        Data_out_2 <= '0;
        rp         <= rp_nxt;
      end
      if (WriteEn_in & Full_out & ~stall) Overflow_out <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_1w_2r.md
# fifo_1w_2r

Single-clock FIFO that accepts one entry per cycle and pops entries in pairs, the counterpart of the 2-write/1-read FIFO. It sits on the SMEM pipeline's consumer side, where a narrow producer (one 65-bit record per cycle) feeds a stage that consumes paired records (for example, forward/backward interval pairs). Unlike the existing FIFOs, it carries true occupancy tracking with full, pair-available and overflow flags.

## Interface
- DATA_WIDTH, 65, entry width in bits
- ADDRESS_WIDTH, 3, pointer width; must be ≥ 1
- FIFO_DEPTH, 1 << ADDRESS_WIDTH, entry count; always a power of two
- Clk  input  1  the only clock; all logic on posedge
- Reset_n  input  1  asynchronous, active-low reset
- Clear_in  input  1  synchronous clear; same effect as reset, takes effect at the next edge
- stall  input  1  freezes both pointers and the count while high
- Data_in  input  DATA_WIDTH  write data
- WriteEn_in  input  1  write request
- Full_out  output  1  count == FIFO_DEPTH
- ReadEn_in  input  1  pair-pop request
- Flush_in  input  1  single-entry pop request; used only when FIFO_1W2R_FLUSH_EN is defined
- Data_out_1  output  DATA_WIDTH  older entry of the popped pair
- Data_out_2  output  DATA_WIDTH  newer entry of the popped pair
- Data_valid  output  1  Data_out_1 is valid this cycle
- Data_valid_2  output  1  Data_out_2 is valid this cycle
- Empty_out  output  1  count < 2, meaning no pair is available
- Count_out  output  ADDRESS_WIDTH+1  current occupancy
- Overflow_out  output  1  sticky flag: a write was dropped because the FIFO was full

## Operation
- Storage: FIFO_DEPTH×DATA_WIDTH register array, indexed by a binary write pointer (wp) and read pointer (rp), each ADDRESS_WIDTH bits and wrapping modulo FIFO_DEPTH.
- Write accepted (wr) = WriteEn_in & !Full_out & !stall.
  - On wr: Mem[wp] <= Data_in; wp <= wp+1.
- Pair pop (rd2) = ReadEn_in & !Empty_out & !stall.
  - On rd2: Data_out_1 <= Mem[rp]; Data_out_2 <= Mem[rp+1] (index wraps modulo depth); rp <= rp+2.
- Count update: count <= count + wr − 2·rd2.
- Simultaneous wr and rd2:
  - Both are allowed.
  - Full_out is evaluated on the pre-pop count, so a write while full is still dropped even if a pop happens in the same cycle.
  - A write to Mem[wp] never aliases the pair being read, because count ≥ 2 and the FIFO is not full.
- Dropped write (WriteEn_in & Full_out & !stall):
  - Data is discarded and nothing else changes.
  - Overflow_out <= 1 and stays set until reset or Clear_in.
- Pop request with Empty_out high:
  - No pointer change; Data_valid stays 0.
  - A single leftover entry stays queued unless flushed (see Configuration).
- stall high:
  - wr and rd2 are forced to 0; Data_valid and Data_valid_2 are 0 next cycle.
  - Data_out_* hold their previous values.
- Reset_n low (async) or Clear_in high (sync):
  - wp, rp and count go to 0.
  - Data_out_1 and Data_out_2 = 0; Data_valid and Data_valid_2 = 0.
  - Full_out = 0, Empty_out = 1, Count_out = 0, Overflow_out = 0.
  - Mem contents are not cleared.
  - Reset mid-operation discards all queued entries.

## Timing
- Write-to-count latency is 1 cycle: the entry is visible in Count_out and Empty_out the cycle after wr.
- Earliest pop:
  - Writes at edges N and N+1 make Empty_out low after edge N+1.
  - A pop asserted in that next cycle returns data one cycle later.
- Read latency: Data_out_* and Data_valid are registered and valid the cycle after the rd2 edge.
- Data_valid and Data_valid_2 are single-cycle pulses per accepted pop.
- Full_out, Empty_out and Count_out are combinational decodes of the count register only; no input appears in any combinational path to them.
- Throughput: one write per cycle and one pair per cycle sustained; the drain rate is twice the fill rate.

## Configuration
- FIFO_1W2R_FLUSH_EN defined:
  - Flush pop (rdf) = Flush_in & !ReadEn_in & (count == 1) & !stall.
  - rdf outputs Data_out_1 <= Mem[rp], Data_out_2 <= 0, Data_valid <= 1, Data_valid_2 <= 0, then rp +1 and count −1.
  - rdf concurrent with wr: count stays unchanged.
- FIFO_1W2R_FLUSH_EN undefined:
  - Flush_in is ignored.
  - Data_valid_2 always equals Data_valid.
  - An odd trailing entry waits for a partner.

## Test plan
- Reset, then write A, B, C, D on consecutive cycles, then ReadEn_in ×2 → pairs (A,B) then (C,D), each with Data_valid=1 one cycle after its pop; Count_out 4→2→0; Empty_out=1 at the end.
- With ADDRESS_WIDTH=3, write 8 entries, then a 9th → Full_out=1, the 9th is dropped, Overflow_out=1 sticky; Count_out=8.
- Fill to 7, then write and pop in the same cycle for 6 cycles → Count_out steps 7→6→…→1; pairs stay in write order across pointer wrap (rp 6→0).
- Write 3 entries, hold stall=1 with ReadEn_in=1 for 3 cycles → no Data_valid; Count_out stays 3. Release stall → one pair out, Count_out=1, Empty_out=1.
- With FIFO_1W2R_FLUSH_EN: count=1 holding X, pulse Flush_in → Data_out_1=X, Data_valid=1, Data_valid_2=0, Data_out_2=0, Count_out=0. Without the macro, the same stimulus → no output.
- Assert Reset_n low asynchronously mid-stream with count=5 and Overflow_out=1 → all outputs return to reset values immediately; the next pair popped is the first pair written after reset.
